// File: rtl/hgw_sat_rnd_pipe_pkg.sv
// Shared definitions for the saturating/rounding datapath blocks.
package hgw_sat_pkg;

    localparam int unsigned RND_MODE_W = 2;

    // Rounding-mode encodings; the fourth code behaves like truncation.
    typedef enum logic [RND_MODE_W-1:0] {
        RND_TRUNC     = 2'b00,
        RND_HALFUP    = 2'b01,
        RND_CONV      = 2'b10,
        RND_TRUNC_ALT = 2'b11
    } rnd_mode_e;

endpackage

// File: rtl/hgw_sat_rnd_pipe_if.sv
// Sample stream interface: input handshake/data and output handshake/data.
interface hgw_sat_rnd_pipe_if #(
    parameter int I_W  = 16,
    parameter int O_W  = 8,
    parameter int N_CH = 2
);
    logic                   in_vld;
    logic                   in_rdy;
    logic [N_CH*I_W-1:0]    in_data;
    logic [1:0]             rnd_mode;
    logic                   sym_en;
    logic                   out_vld;
    logic                   out_rdy;
    logic [N_CH*O_W-1:0]    out_data;
    logic [N_CH-1:0]        out_sat;

    // Producer/consumer environment side.
    modport master (
        output in_vld, in_data, rnd_mode, sym_en, out_rdy,
        input  in_rdy, out_vld, out_data, out_sat
    );

    // Pipeline side.
    modport slave (
        input  in_vld, in_data, rnd_mode, sym_en, out_rdy,
        output in_rdy, out_vld, out_data, out_sat
    );
endinterface

// File: rtl/hgw_sat_rnd_lane.sv
// One lane: round to I_W-SH+1 bits (S1), clip to O_W bits (S2), clip counter.
module hgw_sat_rnd_lane
    import hgw_sat_pkg::*;
#(
    parameter int I_W   = 16,
    parameter int SH    = 4,
    parameter int O_W   = 8,
    parameter int CNT_W = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic signed [I_W-1:0]   x_i,
    input  rnd_mode_e               rnd_mode_i,
    input  logic                    sym_i,
    input  logic                    s1_ld_i,
    input  logic                    s2_ld_i,
    input  logic                    hs_i,
    input  logic                    cnt_clr_i,
    output logic signed [O_W-1:0]   y_o,
    output logic                    sat_o,
    output logic                    sticky_o,
    output logic [CNT_W-1:0]        cnt_o
);
    localparam int R_W = I_W - SH + 1;
    localparam logic signed [R_W-1:0] POS_LIM  = R_W'((2**(O_W-1)) - 1);
    localparam logic signed [R_W-1:0] NEG_SYM  = R_W'(-((2**(O_W-1)) - 1));
    localparam logic signed [R_W-1:0] NEG_FULL = R_W'(-(2**(O_W-1)));

    logic signed [R_W-1:0] rnd_d, rnd_q;
    logic signed [O_W-1:0] y_d, y_q;
    logic                  sat_d, sat_q;
    logic [CNT_W-1:0]      cnt_d, cnt_q;
    logic                  sticky_d, sticky_q;
    logic signed [R_W-1:0] neg_lim;

    if (SH == 0) begin : g_nornd
        assign rnd_d = {x_i[I_W-1], x_i};
    end else begin : g_rnd
        localparam logic [SH-1:0] HALF = SH'(1) << (SH - 1);
        logic signed [R_W-1:0] trunc;
        logic [SH-1:0]         frac;
        logic                  up;

        // Floor shift plus a round-up decision from the dropped fraction.
        always_comb begin
            trunc = R_W'(x_i >>> SH);
            frac  = x_i[SH-1:0];
            up    = 1'b0;
            case (rnd_mode_i)
                RND_HALFUP: up = frac[SH-1];
                RND_CONV:   up = frac[SH-1] && !((frac == HALF) && !trunc[0]);
                default:    up = 1'b0;
            endcase
            rnd_d = trunc + R_W'(up);
        end
    end

    // Clip the S1 value against the mode-dependent limits.
    always_comb begin
        neg_lim = sym_i ? NEG_SYM : NEG_FULL;
        y_d     = rnd_q[O_W-1:0];
        sat_d   = 1'b0;
        if (rnd_q > POS_LIM) begin
            y_d   = POS_LIM[O_W-1:0];
            sat_d = 1'b1;
        end else if (rnd_q < neg_lim) begin
            y_d   = neg_lim[O_W-1:0];
            sat_d = 1'b1;
        end
    end

    // Saturating clip counter and sticky flag; clear wins over increment.
    always_comb begin
        cnt_d    = cnt_q;
        sticky_d = sticky_q;
        if (cnt_clr_i) begin
            cnt_d    = '0;
            sticky_d = 1'b0;
        end else if (hs_i && sat_q) begin
            sticky_d = 1'b1;
            if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // S1 register: rounded value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       rnd_q <= '0;
        else if (s1_ld_i) rnd_q <= rnd_d;
    end

    // S2 register: clipped value and clip flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q   <= '0;
            sat_q <= 1'b0;
        end else if (s2_ld_i) begin
            y_q   <= y_d;
            sat_q <= sat_d;
        end
    end

    // Counter state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            sticky_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            sticky_q <= sticky_d;
        end
    end

    assign y_o      = y_q;
    assign sat_o    = sat_q;
    assign sticky_o = sticky_q;
    assign cnt_o    = cnt_q;
endmodule

// File: rtl/hgw_sat_rnd_pipe.sv
// Two-stage round/saturate pipeline over N_CH packed lanes with handshake.
module hgw_sat_rnd_pipe
    import hgw_sat_pkg::*;
#(
    parameter int I_W   = 16,
    parameter int SH    = 4,
    parameter int O_W   = 8,
    parameter int N_CH  = 2,
    parameter int CNT_W = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    hgw_sat_rnd_pipe_if.slave       bus,
    input  logic                    cnt_clr,
    output logic [N_CH-1:0]         sat_sticky,
    output logic [N_CH*CNT_W-1:0]   sat_cnt
);
`ifdef RTL_SIM
    if ((I_W - SH < O_W) || (O_W < 2)) begin : g_param_err
        $error("hgw_sat_rnd_pipe: requires I_W-SH >= O_W >= 2");
    end
`endif

    logic s1_vld_d, s1_vld_q, s2_vld_d, s2_vld_q, sym_q;
    logic s1_adv, s2_adv, s1_ld, s2_ld, out_hs;

    logic signed [O_W-1:0] lane_y      [N_CH];
    logic                  lane_sat    [N_CH];
    logic                  lane_sticky [N_CH];
    logic [CNT_W-1:0]      lane_cnt    [N_CH];

    // Stage advance and valid propagation.
    always_comb begin
        s2_adv   = !s2_vld_q || bus.out_rdy;
        s1_adv   = !s1_vld_q || s2_adv;
        s1_ld    = s1_adv && bus.in_vld;
        s2_ld    = s2_adv && s1_vld_q;
        s1_vld_d = s1_adv ? bus.in_vld : s1_vld_q;
        s2_vld_d = s2_adv ? s1_vld_q : s2_vld_q;
        out_hs   = s2_vld_q && bus.out_rdy;
    end

    // Valid flags and the clip mode travelling with the S1 sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_q <= 1'b0;
            s2_vld_q <= 1'b0;
            sym_q    <= 1'b0;
        end else begin
            s1_vld_q <= s1_vld_d;
            s2_vld_q <= s2_vld_d;
            if (s1_ld) sym_q <= bus.sym_en;
        end
    end

    for (genvar k = 0; k < N_CH; k++) begin : g_lane
        hgw_sat_rnd_lane #(
            .I_W   (I_W),
            .SH    (SH),
            .O_W   (O_W),
            .CNT_W (CNT_W)
        ) u_lane (
            .clk        (clk),
            .rst_n      (rst_n),
            .x_i        (bus.in_data[k*I_W +: I_W]),
            .rnd_mode_i (rnd_mode_e'(bus.rnd_mode)),
            .sym_i      (sym_q),
            .s1_ld_i    (s1_ld),
            .s2_ld_i    (s2_ld),
            .hs_i       (out_hs),
            .cnt_clr_i  (cnt_clr),
            .y_o        (lane_y[k]),
            .sat_o      (lane_sat[k]),
            .sticky_o   (lane_sticky[k]),
            .cnt_o      (lane_cnt[k])
        );
    end

    // Pack per-lane results onto the output buses.
    always_comb begin
        bus.out_data = '0;
        bus.out_sat  = '0;
        sat_sticky   = '0;
        sat_cnt      = '0;
        for (int unsigned k = 0; k < N_CH; k++) begin
            bus.out_data[k*O_W +: O_W]  = lane_y[k];
            bus.out_sat[k]              = lane_sat[k];
            sat_sticky[k]               = lane_sticky[k];
            sat_cnt[k*CNT_W +: CNT_W]   = lane_cnt[k];
        end
    end

    assign bus.in_rdy  = s1_adv;
    assign bus.out_vld = s2_vld_q;
endmodule

// File: tb/tb_hgw_sat_rnd_pipe.sv
// Directed plus random checks of hgw_sat_rnd_pipe against an arithmetic model.
module tb_hgw_sat_rnd_pipe;
    localparam int I_W = 16, SH = 4, O_W = 8, N_CH = 2, CNT_W = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic cnt_clr = 1'b0;
    logic [N_CH-1:0]       sat_sticky;
    logic [N_CH*CNT_W-1:0] sat_cnt;

    hgw_sat_rnd_pipe_if #(.I_W(I_W), .O_W(O_W), .N_CH(N_CH)) bus ();

    hgw_sat_rnd_pipe #(
        .I_W(I_W), .SH(SH), .O_W(O_W), .N_CH(N_CH), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .cnt_clr(cnt_clr),
        .sat_sticky(sat_sticky), .sat_cnt(sat_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N_CH*O_W-1:0] y;
        logic [N_CH-1:0]     sat;
    } exp_t;

    exp_t sb[$];
    int   m_cnt[N_CH];
    bit   m_sticky[N_CH];
    int   n_assert = 0;
    int   n_fail = 0;
    int   n_out = 0;

    bit                  d_vld, d_sym, d_ordy, d_clr;
    logic [N_CH*I_W-1:0] d_data;
    logic [1:0]          d_mode;
    bit                  s_acc, s_hs, s_ovld, s_irdy;
    bit                  hold;
    logic [N_CH*O_W-1:0] hold_y;
    logic [N_CH-1:0]     hold_sat;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected lane outputs from floor division and clamping.
    function automatic exp_t ref_model(input logic [N_CH*I_W-1:0] data, input logic [1:0] mode,
                                       input logic sym);
        exp_t e;
        int x, q, r, d, c, hi, lo;
        e.y   = '0;
        e.sat = '0;
        d  = 1 << SH;
        hi = (1 << (O_W - 1)) - 1;
        lo = -(1 << (O_W - 1)) + (sym ? 1 : 0);
        for (int k = 0; k < N_CH; k++) begin
            x = $signed(data[k*I_W +: I_W]);
            q = x / d;
            r = x - q * d;
            if (r < 0) begin
                q--;
                r += d;
            end
            if (mode == 2'b01 && 2 * r >= d) q++;
            else if (mode == 2'b10 && (2 * r > d || (2 * r == d && (q % 2) != 0))) q++;
            c = (q > hi) ? hi : ((q < lo) ? lo : q);
            e.y[k*O_W +: O_W] = O_W'(c);
            e.sat[k] = (c != q);
        end
        return e;
    endfunction

    // One clock: drive at negedge, observe 1 time unit later, update model.
    task automatic tick();
        exp_t e;
        logic [N_CH-1:0]       clip_hs;
        logic [N_CH*CNT_W-1:0] mc;
        logic [N_CH-1:0]       ms;
        bus.in_vld   = d_vld;
        bus.in_data  = d_data;
        bus.rnd_mode = d_mode;
        bus.sym_en   = d_sym;
        bus.out_rdy  = d_ordy;
        cnt_clr      = d_clr;
        #1;
        s_irdy = bus.in_rdy;
        s_ovld = bus.out_vld;
        s_acc  = d_vld && bus.in_rdy;
        s_hs   = bus.out_vld && d_ordy;
        for (int k = 0; k < N_CH; k++) begin
            mc[k*CNT_W +: CNT_W] = CNT_W'(m_cnt[k]);
            ms[k] = m_sticky[k];
        end
        check("sat_cnt", sat_cnt, mc);
        check("sat_sticky", sat_sticky, ms);
        if (hold) begin
            check("hold_vld", bus.out_vld, 1);
            check("hold_data", bus.out_data, hold_y);
            check("hold_sat", bus.out_sat, hold_sat);
        end
        hold     = bus.out_vld && !d_ordy;
        hold_y   = bus.out_data;
        hold_sat = bus.out_sat;
        clip_hs  = '0;
        if (s_hs) begin
            if (sb.size() == 0) begin
                check("unexpected_out_vld", bus.out_vld, 0);
            end else begin
                e = sb.pop_front();
                n_out++;
                check("out_data", bus.out_data, e.y);
                check("out_sat", bus.out_sat, e.sat);
                clip_hs = e.sat;
            end
        end
        for (int k = 0; k < N_CH; k++) begin
            if (d_clr) begin
                m_cnt[k]    = 0;
                m_sticky[k] = 1'b0;
            end else if (clip_hs[k]) begin
                m_sticky[k] = 1'b1;
                if (m_cnt[k] < (1 << CNT_W) - 1) m_cnt[k]++;
            end
        end
        if (s_acc) sb.push_back(ref_model(d_data, d_mode, d_sym));
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_out_vld", bus.out_vld, 0);
        check("rst_out_data", bus.out_data, 0);
        check("rst_out_sat", bus.out_sat, 0);
        check("rst_sticky", sat_sticky, 0);
        check("rst_cnt", sat_cnt, 0);
        check("rst_in_rdy", bus.in_rdy, 1);
        sb.delete();
        hold = 1'b0;
        for (int k = 0; k < N_CH; k++) begin
            m_cnt[k]    = 0;
            m_sticky[k] = 1'b0;
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic send(input logic [N_CH*I_W-1:0] data, input logic [1:0] mode, input bit sym);
        d_vld  = 1'b1;
        d_data = data;
        d_mode = mode;
        d_sym  = sym;
        tick();
        d_vld = 1'b0;
    endtask

    task automatic idle(input int n);
        d_vld = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int idx;
        int n0;
        d_vld = 0; d_sym = 0; d_ordy = 1; d_clr = 0; d_data = '0; d_mode = '0;
        bus.in_vld = 0; bus.in_data = '0; bus.rnd_mode = '0; bus.sym_en = 0; bus.out_rdy = 1;
        hold = 0;
        @(negedge clk);
        do_reset();

        // Latency: out_vld exactly two cycles after acceptance.
        send({16'd40, 16'd24}, 2'b00, 1'b0);
        check("lat_accept", s_acc, 1);
        idle(1);
        check("lat_cycle1_vld", s_ovld, 0);
        idle(1);
        check("lat_cycle2_vld", s_ovld, 1);
        idle(2);

        // Rounding modes on ties and non-ties.
        for (int m = 0; m < 3; m++) begin
            send({16'd40, 16'd24}, 2'(m), 1'b0);
            send({16'hFFE8, 16'hFFE8}, 2'(m), 1'b1);
        end
        send({16'd40, 16'hFFE8}, 2'b11, 1'b0);
        // Clipping, symmetric clip and rounding overflow.
        send({16'h8000, 16'h7FFF}, 2'b00, 1'b0);
        send({16'hF808, 16'hF808}, 2'b00, 1'b1);
        send({16'h07F8, 16'h07F8}, 2'b01, 1'b0);
        send({16'h8000, 16'h8000}, 2'b10, 1'b1);
        idle(4);
        check("directed_drained", sb.size(), 0);

        // Backpressure: out_rdy low for three cycles while streaming five samples.
        idx = 0;
        n0 = n_out;
        for (int t = 0; t < 16; t++) begin
            d_vld  = (idx < 5);
            d_data = {16'(idx * 700 - 1000), 16'(37 - idx * 500)};
            d_mode = 2'b01;
            d_sym  = 1'b0;
            d_ordy = !(t >= 2 && t <= 4);
            tick();
            if (t == 2) begin
                check("bp_in_rdy_low", s_irdy, 0);
                check("bp_accepts", idx, 2);
            end
            if (s_acc) idx++;
        end
        d_vld  = 1'b0;
        d_ordy = 1'b1;
        check("bp_delivered", n_out - n0, 5);
        check("bp_drained", sb.size(), 0);

        // Counter: five lane-0 clips saturate a 2-bit counter.
        d_clr = 1'b1;
        idle(1);
        d_clr = 1'b0;
        for (int i = 0; i < 5; i++) send({16'h0000, 16'h7FFF}, 2'b00, 1'b0);
        idle(3);
        check("cnt_lane0_sat", sat_cnt[1:0], 3);
        check("cnt_lane1_zero", sat_cnt[3:2], 0);
        check("sticky_lanes", sat_sticky, 2'b01);
        // Clear coincident with a clipped output handshake.
        send({16'h0000, 16'h7FFF}, 2'b00, 1'b0);
        idle(1);
        d_clr = 1'b1;
        idle(1);
        d_clr = 1'b0;
        check("clr_coincident_hs", s_hs, 1);
        check("clr_cnt_zero", sat_cnt, 0);
        check("clr_sticky_zero", sat_sticky, 0);

        // Reset with two samples in flight.
        send({16'h0000, 16'h7FFF}, 2'b00, 1'b0);
        idle(3);
        send({16'h7FFF, 16'h7FFF}, 2'b00, 1'b0);
        send({16'h0100, 16'h0100}, 2'b00, 1'b0);
        check("pre_rst_vld", bus.out_vld, 1);
        check("pre_rst_sticky", sat_sticky, 2'b01);
        do_reset();
        for (int i = 0; i < 4; i++) begin
            idle(1);
            check("post_rst_no_vld", s_ovld, 0);
        end
        check("post_rst_in_rdy", s_irdy, 1);

        // Random traffic with random backpressure and occasional clears.
        for (int i = 0; i < 300; i++) begin
            d_vld = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 1) == 1) d_data = $urandom;
            else d_data = {16'($urandom_range(0, 4095)) - 16'd2048,
                           16'($urandom_range(0, 4095)) - 16'd2048};
            d_mode = 2'($urandom_range(0, 3));
            d_sym  = ($urandom_range(0, 1) == 1);
            d_ordy = ($urandom_range(0, 3) != 0);
            d_clr  = ($urandom_range(0, 31) == 0);
            tick();
        end
        d_clr  = 1'b0;
        d_ordy = 1'b1;
        idle(4);
        check("random_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
